// File: rtl/pedestrian_signal_ctrl.sv
// Pedestrian crossing controller that sits behind the two-way intersection
// light FSM. It has one crossing FSM per direction. Each FSM latches button
// requests and drives WALK, then a flashing DON'T-WALK with a countdown.
// A sticky fault forces both crossings safe on any illegal vehicle-light pattern.

// One crossing direction: button synchroniser, request latch and IDLE/WALK/FLASH FSM.
module ped_dir #(
    parameter int WALK_CYCLES  = 4,
    parameter int FLASH_CYCLES = 6,
    parameter int FLASH_HALF   = 1,
    parameter int CW           = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          force_safe,
    input  logic          btn,
    input  logic          green,
    input  logic          red,
    output logic          walk,
    output logic          dont_walk,
    output logic          req_wait,
    output logic [CW-1:0] count,
    output logic          abort_set,
    output logic [1:0]    state_dbg
);
    localparam int TW = $clog2(WALK_CYCLES + 1);
    localparam int HW = $clog2(FLASH_HALF + 1);
    localparam logic [TW-1:0] WALK_LOAD  = TW'(WALK_CYCLES - 1);
    localparam logic [HW-1:0] HALF_LOAD  = HW'(FLASH_HALF - 1);
    localparam logic [CW-1:0] FLASH_LOAD = CW'(FLASH_CYCLES);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WALK = 2'd1, S_FLASH = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          btn_s1, btn_s2, btn_s3;
    logic          green_q;
    logic          walk_q, walk_d;
    logic          dont_walk_q, dont_walk_d;
    logic          wait_q, wait_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [HW-1:0] half_q, half_d;
    logic          abort_d;

    logic btn_edge, green_rise, start, walk_done, flash_end;

    // A request is served only on a fresh green. A press that is detected on
    // that same edge is held for the next green.
    assign btn_edge   = btn_s2 & ~btn_s3;
    assign green_rise = green & ~green_q;
    assign start      = (state_q == S_IDLE) && green_rise && wait_q;
    assign walk_done  = !green || (timer_q == '0);
    assign flash_end  = red || (count_q == CW'(1));

    // Button synchroniser/edge history and previous green sample.
    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            btn_s3  <= 1'b0;
            green_q <= 1'b0;
        end else begin
            btn_s1  <= btn;
            btn_s2  <= btn_s1;
            btn_s3  <= btn_s2;
            green_q <= green;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic. A fault forces IDLE. Red during FLASH truncates it.
    always_comb begin
        state_d = state_q;
        if (force_safe) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start)     state_d = S_WALK;
                S_WALK:  if (walk_done) state_d = S_FLASH;
                S_FLASH: if (flash_end) state_d = S_IDLE;
                default:                state_d = S_IDLE;
            endcase
        end
    end

    // Next values of the registered lamps, countdown, timers and request latch.
    always_comb begin
        walk_d      = walk_q;
        dont_walk_d = dont_walk_q;
        count_d     = count_q;
        timer_d     = timer_q;
        half_d      = half_q;
        abort_d     = 1'b0;
        wait_d      = btn_edge | (wait_q & ~start);
        if (force_safe) begin
            walk_d      = 1'b0;
            dont_walk_d = 1'b1;
            count_d     = '0;
            wait_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    walk_d      = 1'b0;
                    dont_walk_d = 1'b1;
                    count_d     = '0;
                    if (start) begin
                        walk_d      = 1'b1;
                        dont_walk_d = 1'b0;
                        timer_d     = WALK_LOAD;
                    end
                end
                S_WALK: begin
                    if (walk_done) begin
                        walk_d      = 1'b0;
                        dont_walk_d = 1'b1;
                        count_d     = FLASH_LOAD;
                        half_d      = HALF_LOAD;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_FLASH: begin
                    if (flash_end) begin
                        walk_d      = 1'b0;
                        dont_walk_d = 1'b1;
                        count_d     = '0;
                        abort_d     = red;
                    end else begin
                        count_d = count_q - CW'(1);
                        if (half_q == '0) begin
                            dont_walk_d = ~dont_walk_q;
                            half_d      = HALF_LOAD;
                        end else begin
                            half_d = half_q - HW'(1);
                        end
                    end
                end
                default: begin
                    walk_d      = 1'b0;
                    dont_walk_d = 1'b1;
                    count_d     = '0;
                end
            endcase
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            wait_q      <= 1'b0;
            count_q     <= '0;
            timer_q     <= '0;
            half_q      <= '0;
        end else begin
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            wait_q      <= wait_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            half_q      <= half_d;
        end
    end

    assign walk      = walk_q;
    assign dont_walk = dont_walk_q;
    assign req_wait  = wait_q;
    assign count     = count_q;
    assign abort_set = abort_d;
    assign state_dbg = state_q;
endmodule

// Top: two independent crossing FSMs, the light-pattern check and the sticky fault.
module pedestrian_signal_ctrl #(
    parameter int WALK_CYCLES  = 4,
    parameter int FLASH_CYCLES = 6,
    parameter int FLASH_HALF   = 1,
    parameter int CW           = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ns_red,
    input  logic          ns_yellow,
    input  logic          ns_green,
    input  logic          ew_red,
    input  logic          ew_yellow,
    input  logic          ew_green,
    input  logic          ped_btn_ns,
    input  logic          ped_btn_ew,
    output logic          ns_walk,
    output logic          ew_walk,
    output logic          ns_dont_walk,
    output logic          ew_dont_walk,
    output logic          ns_wait,
    output logic          ew_wait,
    output logic [CW-1:0] ns_count,
    output logic [CW-1:0] ew_count,
    output logic          abort,
    output logic          fault
);
    logic       illegal, force_safe;
    logic       fault_q, abort_q;
    logic       ns_abort_set, ew_abort_set;
    logic [1:0] ns_state, ew_state;

    // Legal: each direction one-hot, and at least one direction showing red.
    assign illegal = !$onehot({ns_red, ns_yellow, ns_green}) ||
                     !$onehot({ew_red, ew_yellow, ew_green}) ||
                     (!ns_red && !ew_red);
    assign force_safe = fault_q | illegal;

    // Sticky fault flag and registered abort pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fault_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            if (illegal) fault_q <= 1'b1;
            abort_q <= ns_abort_set | ew_abort_set;
        end
    end

    ped_dir #(
        .WALK_CYCLES(WALK_CYCLES), .FLASH_CYCLES(FLASH_CYCLES),
        .FLASH_HALF(FLASH_HALF), .CW(CW)
    ) u_ns (
        .clk(clk), .reset(reset), .force_safe(force_safe),
        .btn(ped_btn_ns), .green(ns_green), .red(ns_red),
        .walk(ns_walk), .dont_walk(ns_dont_walk), .req_wait(ns_wait),
        .count(ns_count), .abort_set(ns_abort_set), .state_dbg(ns_state)
    );

    ped_dir #(
        .WALK_CYCLES(WALK_CYCLES), .FLASH_CYCLES(FLASH_CYCLES),
        .FLASH_HALF(FLASH_HALF), .CW(CW)
    ) u_ew (
        .clk(clk), .reset(reset), .force_safe(force_safe),
        .btn(ped_btn_ew), .green(ew_green), .red(ew_red),
        .walk(ew_walk), .dont_walk(ew_dont_walk), .req_wait(ew_wait),
        .count(ew_count), .abort_set(ew_abort_set), .state_dbg(ew_state)
    );

    assign abort = abort_q;
    assign fault = fault_q;
endmodule

// File: tb/tb_pedestrian_signal_ctrl.sv
// Directed bench for pedestrian_signal_ctrl. Each step drives one cycle of
// inputs and queues the hand-computed outputs expected after that edge. A
// monitor pops and compares one entry after every rising edge.
module tb_pedestrian_signal_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
    logic       ped_btn_ns, ped_btn_ew;
    logic       ns_walk, ew_walk, ns_dont_walk, ew_dont_walk, ns_wait, ew_wait;
    logic [3:0] ns_count, ew_count;
    logic       abort, fault;

    logic [15:0] exp_q[$];
    int          id_q[$];
    int          total = 0;
    int          bad = 0;
    int          step_no = 0;

    // Light patterns {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}.
    localparam logic [5:0] L_NSG  = 6'b001_100;
    localparam logic [5:0] L_NSY  = 6'b010_100;
    localparam logic [5:0] L_ALLR = 6'b100_100;
    localparam logic [5:0] L_EWG  = 6'b100_001;
    localparam logic [5:0] L_EWY  = 6'b100_010;
    localparam logic [5:0] L_ILL  = 6'b001_001;

    // Per-direction expectation {walk, dont_walk, wait, count[3:0]}.
    localparam logic [6:0] D_I  = 7'b0_1_0_0000;
    localparam logic [6:0] D_IW = 7'b0_1_1_0000;
    localparam logic [6:0] D_W  = 7'b1_0_0_0000;

    pedestrian_signal_ctrl dut (
        .clk(clk), .reset(reset),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .ped_btn_ns(ped_btn_ns), .ped_btn_ew(ped_btn_ew),
        .ns_walk(ns_walk), .ew_walk(ew_walk),
        .ns_dont_walk(ns_dont_walk), .ew_dont_walk(ew_dont_walk),
        .ns_wait(ns_wait), .ew_wait(ew_wait),
        .ns_count(ns_count), .ew_count(ew_count),
        .abort(abort), .fault(fault)
    );

    // Clock.
    always #5 clk = ~clk;

    function automatic logic [6:0] fl(input logic dw, input logic [3:0] c);
        return {1'b0, dw, 1'b0, c};
    endfunction

    function automatic logic [15:0] ex(input logic [6:0] n, input logic [6:0] e,
                                       input logic ab, input logic f);
        return {n, e, ab, f};
    endfunction

    // Driver: one cycle of stimulus plus the outputs expected after the edge.
    task automatic step(input logic rst_n, input logic [5:0] l, input logic bn,
                        input logic be, input logic [15:0] e);
        @(negedge clk);
        reset = rst_n;
        {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = l;
        ped_btn_ns = bn;
        ped_btn_ew = be;
        step_no++;
        exp_q.push_back(e);
        id_q.push_back(step_no);
    endtask

    task automatic s(input logic [5:0] l, input logic bn, input logic be,
                     input logic [6:0] n, input logic [6:0] e);
        step(1'b1, l, bn, be, ex(n, e, 1'b0, 1'b0));
    endtask

    // Monitor/scoreboard.
    always @(posedge clk) begin
        logic [15:0] act, e;
        int id;
        #1;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            id  = id_q.pop_front();
            act = {ns_walk, ns_dont_walk, ns_wait, ns_count,
                   ew_walk, ew_dont_walk, ew_wait, ew_count, abort, fault};
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL step%0d outputs got=%b expected=%b", id, act, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = L_ALLR;
        ped_btn_ns = 1'b0;
        ped_btn_ew = 1'b0;

        // Reset held two cycles, then idle.
        step(1'b0, L_ALLR, 0, 0, ex(D_I, D_I, 0, 0));
        step(1'b0, L_ALLR, 0, 0, ex(D_I, D_I, 0, 0));
        for (int i = 0; i < 3; i++) s(L_ALLR, 0, 0, D_I, D_I);

        // NS request during EW green, full walk/flash on the next NS green.
        s(L_EWG, 0, 0, D_I, D_I);
        s(L_EWG, 1, 0, D_I, D_I);
        s(L_EWG, 0, 0, D_I, D_I);
        s(L_EWG, 0, 0, D_IW, D_I);
        s(L_EWY, 0, 0, D_IW, D_I);
        s(L_ALLR, 0, 0, D_IW, D_I);
        for (int i = 0; i < 4; i++) s(L_NSG, 0, 0, D_W, D_I);
        s(L_NSG, 0, 0, fl(1, 6), D_I);
        s(L_NSG, 0, 0, fl(0, 5), D_I);
        s(L_NSG, 0, 0, fl(1, 4), D_I);
        s(L_NSG, 0, 0, fl(0, 3), D_I);
        s(L_NSG, 0, 0, fl(1, 2), D_I);
        s(L_NSG, 0, 0, fl(0, 1), D_I);
        s(L_NSG, 0, 0, D_I, D_I);
        s(L_NSY, 0, 0, D_I, D_I);
        s(L_ALLR, 0, 0, D_I, D_I);

        // Walk cut short by yellow; flash still runs to completion.
        s(L_ALLR, 1, 0, D_I, D_I);
        s(L_ALLR, 0, 0, D_I, D_I);
        s(L_ALLR, 0, 0, D_IW, D_I);
        s(L_NSG, 0, 0, D_W, D_I);
        s(L_NSG, 0, 0, D_W, D_I);
        s(L_NSY, 0, 0, fl(1, 6), D_I);
        s(L_NSY, 0, 0, fl(0, 5), D_I);
        s(L_NSY, 0, 0, fl(1, 4), D_I);
        s(L_NSY, 0, 0, fl(0, 3), D_I);
        s(L_NSY, 0, 0, fl(1, 2), D_I);
        s(L_NSY, 0, 0, fl(0, 1), D_I);
        s(L_NSY, 0, 0, D_I, D_I);
        s(L_ALLR, 0, 0, D_I, D_I);

        // Red arriving in the third flash cycle aborts for one cycle.
        s(L_ALLR, 1, 0, D_I, D_I);
        s(L_ALLR, 0, 0, D_I, D_I);
        s(L_ALLR, 0, 0, D_IW, D_I);
        s(L_NSG, 0, 0, D_W, D_I);
        s(L_NSG, 0, 0, D_W, D_I);
        s(L_NSY, 0, 0, fl(1, 6), D_I);
        s(L_NSY, 0, 0, fl(0, 5), D_I);
        step(1'b1, L_ALLR, 0, 0, ex(D_I, D_I, 1, 0));
        s(L_ALLR, 0, 0, D_I, D_I);

        // Request detected on the same edge as green rise: served next green.
        s(L_ALLR, 1, 0, D_I, D_I);
        s(L_ALLR, 0, 0, D_I, D_I);
        s(L_NSG, 0, 0, D_IW, D_I);
        s(L_NSG, 0, 0, D_IW, D_I);
        s(L_NSY, 0, 0, D_IW, D_I);
        s(L_ALLR, 0, 0, D_IW, D_I);
        s(L_NSG, 0, 0, D_W, D_I);
        s(L_NSY, 0, 0, fl(1, 6), D_I);
        step(1'b1, L_ALLR, 0, 0, ex(D_I, D_I, 1, 0));
        s(L_ALLR, 0, 0, D_I, D_I);

        // Press mid-green: no walk this green, served on the next one.
        s(L_NSG, 0, 0, D_I, D_I);
        s(L_NSG, 1, 0, D_I, D_I);
        s(L_NSG, 0, 0, D_I, D_I);
        s(L_NSG, 0, 0, D_IW, D_I);
        s(L_NSY, 0, 0, D_IW, D_I);
        s(L_ALLR, 0, 0, D_IW, D_I);
        s(L_NSG, 0, 0, D_W, D_I);
        s(L_NSY, 0, 0, fl(1, 6), D_I);
        step(1'b1, L_ALLR, 0, 0, ex(D_I, D_I, 1, 0));
        s(L_ALLR, 0, 0, D_I, D_I);

        // Both buttons held together: one request each, NS then EW served.
        s(L_ALLR, 1, 1, D_I, D_I);
        s(L_ALLR, 1, 1, D_I, D_I);
        s(L_ALLR, 1, 1, D_IW, D_IW);
        s(L_ALLR, 0, 0, D_IW, D_IW);
        for (int i = 0; i < 4; i++) s(L_NSG, 0, 0, D_W, D_IW);
        s(L_NSG, 0, 0, fl(1, 6), D_IW);
        s(L_NSG, 0, 0, fl(0, 5), D_IW);
        s(L_NSG, 0, 0, fl(1, 4), D_IW);
        s(L_NSG, 0, 0, fl(0, 3), D_IW);
        s(L_NSG, 0, 0, fl(1, 2), D_IW);
        s(L_NSG, 0, 0, fl(0, 1), D_IW);
        s(L_NSG, 0, 0, D_I, D_IW);
        s(L_NSY, 0, 0, D_I, D_IW);
        s(L_ALLR, 0, 0, D_I, D_IW);
        for (int i = 0; i < 4; i++) s(L_EWG, 0, 0, D_I, D_W);
        s(L_EWG, 0, 0, D_I, fl(1, 6));
        s(L_EWG, 0, 0, D_I, fl(0, 5));
        s(L_EWG, 0, 0, D_I, fl(1, 4));
        s(L_EWG, 0, 0, D_I, fl(0, 3));
        s(L_EWG, 0, 0, D_I, fl(1, 2));
        s(L_EWG, 0, 0, D_I, fl(0, 1));
        s(L_EWG, 0, 0, D_I, D_I);
        s(L_EWY, 0, 0, D_I, D_I);
        s(L_ALLR, 0, 0, D_I, D_I);

        // Illegal pattern during an NS walk: sticky safe fault until reset.
        s(L_ALLR, 1, 1, D_I, D_I);
        s(L_ALLR, 0, 0, D_I, D_I);
        s(L_ALLR, 0, 0, D_IW, D_IW);
        s(L_NSG, 0, 0, D_W, D_IW);
        s(L_NSG, 0, 0, D_W, D_IW);
        step(1'b1, L_ILL, 0, 0, ex(D_I, D_I, 0, 1));
        step(1'b1, L_EWG, 0, 0, ex(D_I, D_I, 0, 1));
        step(1'b1, L_EWG, 0, 1, ex(D_I, D_I, 0, 1));
        step(1'b1, L_EWG, 0, 0, ex(D_I, D_I, 0, 1));
        step(1'b1, L_EWG, 1, 0, ex(D_I, D_I, 0, 1));
        step(1'b1, L_EWY, 0, 0, ex(D_I, D_I, 0, 1));
        step(1'b1, L_ALLR, 0, 0, ex(D_I, D_I, 0, 1));
        step(1'b1, L_ALLR, 0, 0, ex(D_I, D_I, 0, 1));
        step(1'b0, L_ALLR, 0, 0, ex(D_I, D_I, 0, 0));
        s(L_ALLR, 0, 0, D_I, D_I);
        s(L_ALLR, 0, 0, D_I, D_I);

        // Reset in mid-walk returns everything to reset values.
        s(L_ALLR, 1, 0, D_I, D_I);
        s(L_ALLR, 0, 0, D_I, D_I);
        s(L_ALLR, 0, 0, D_IW, D_I);
        s(L_NSG, 0, 0, D_W, D_I);
        step(1'b0, L_NSG, 0, 0, ex(D_I, D_I, 0, 0));
        s(L_ALLR, 0, 0, D_I, D_I);
        s(L_ALLR, 0, 0, D_I, D_I);

        // Let the monitor consume the last entry.
        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pedestrian_signal_ctrl.md
# pedestrian_signal_ctrl

Pedestrian crossing controller placed directly downstream of the two-way intersection light FSM. It consumes the six vehicle light outputs (NS/EW red/yellow/green), latches pedestrian push-button requests, and drives WALK / flashing DON'T-WALK signals with a countdown for each crossing. It also checks the incoming light pattern and forces a safe, sticky fault state on any illegal combination.

## Interface
- WALK_CYCLES, 4: cycles of steady WALK per served request
- FLASH_CYCLES, 6: cycles of flashing DON'T-WALK after WALK
- FLASH_HALF, 1: cycles per flash phase (toggle period)
- CW, 4: countdown output width; FLASH_CYCLES must be ≤ 2^CW−1
- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-low (reset==0 resets on the clock edge)
- ns_red, ns_yellow, ns_green  in  1 each  NS vehicle lights from intersection FSM
- ew_red, ew_yellow, ew_green  in  1 each  EW vehicle lights from intersection FSM
- ped_btn_ns, ped_btn_ew  in  1 each  raw buttons (NS crossing runs parallel to NS traffic)
- ns_walk, ew_walk  out  1 each  steady WALK lamp
- ns_dont_walk, ew_dont_walk  out  1 each  DON'T-WALK lamp (steady or flashing)
- ns_wait, ew_wait  out  1 each  request-latched indicator
- ns_count, ew_count  out  CW each  flash countdown, 0 outside FLASH
- abort  out  1  one-cycle pulse when a FLASH is truncated by red
- fault  out  1  sticky illegal-light-pattern flag

## Operation
- All outputs registered. Reset values: walk=0, dont_walk=1, wait=0, count=0, abort=0, fault=0; states IDLE; sync/edge flops 0.
- Buttons: 2-flop synchroniser, then rising-edge detect; a detected edge sets the direction's request latch (wait=1). A held button produces one request. Presses while wait=1 or during WALK/FLASH set/keep the latch for the next green.
- Green rising edge per direction: green==1 this sample, 0 previous sample (prev register reset to 0).
- Per-direction FSM, states IDLE, WALK, FLASH:
- IDLE: walk=0, dont_walk=1, count=0. On green rising edge with wait==1 → WALK; wait cleared on the same edge. Requests arriving mid-green wait for the next green rising edge.
- WALK: walk=1, dont_walk=0 for WALK_CYCLES cycles → FLASH. If green drops (yellow or red) before expiry → FLASH immediately.
- FLASH: walk=0; dont_walk=1 in first phase, toggling every FLASH_HALF cycles; count loads FLASH_CYCLES on entry, decrements each cycle; after the cycle with count==1 → IDLE. If the direction's red==1 while in FLASH → IDLE and abort pulses one cycle.
- Legal pattern: each direction exactly one-hot, and not both directions non-red. Any other sampled pattern sets fault.
- Fault: sticky until reset; both FSMs forced to IDLE, request latches and wait cleared, walk=0, dont_walk=1 steady, count=0; buttons ignored.
- NS and EW FSMs are independent; simultaneous button edges on both set both latches.
- Reset asserted mid-operation returns every output to reset values on that edge regardless of state.

## Timing
- Button: ped_btn high sampled at edge k → wait=1 after edge k+2.
- Walk start: green==1 first sampled at edge n (wait==1) → walk=1, wait=0 after edge n; WALK occupies edges n..n+WALK_CYCLES−1 outputs; FLASH outputs begin after edge n+WALK_CYCLES.
- FLASH with FLASH_HALF=1: dont_walk sequence 1,0,1,0,1,0; count 6,5,4,3,2,1; then IDLE (dont_walk=1, count=0).
- Fault: illegal pattern sampled at edge f → fault=1 and safe outputs after edge f.
- Button edge and green rising edge on the same edge with wait==0: request latches, no walk this green.

## Test plan
- Reset held low 2 cycles, released → all walk=0, dont_walk=1, wait=0, count=0, fault=0 for all cycles until a request.
- ped_btn_ns pulsed during EW green, NS green rises later → wait=1 until NS green rising edge, then walk=1 for 4 cycles, flash 1,0,1,0,1,0 with count 6..1, back to IDLE.
- NS green lasts only 2 cycles after walk start → WALK truncated after 2 cycles, full 6-cycle FLASH; if NS red arrives at flash cycle 3 → IDLE, abort=1 for exactly one cycle.
- Button pressed mid-NS-green (after rising edge) → no walk this green, wait stays 1, walk served on next NS green.
- Inject ns_green=1 and ew_green=1 → fault=1 next edge, both walk=0, dont_walk=1, stays set through further legal patterns and button presses until reset=0.
- Both buttons pressed same cycle, normal NS→EW cycle → NS served on NS green, EW served on following EW green, never walk on both simultaneously.
